// File: rtl/sipo_frame_ctrl.sv
// Start/count framed serial-to-parallel capture with a valid/ready frame output.
// Optional idle-gap abort in CAPTURE when SIPO_CTRL_TIMEOUT_EN is defined.
module sipo_frame_ctrl #(
    parameter int DATA_WID    = 8,
    parameter int MEMORY_WID  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           ser_valid,
    input  logic                           ser_bit,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic [DATA_WID*MEMORY_WID-1:0] frame_data,
    output logic [$clog2(MEMORY_WID+1)-1:0] word_cnt,
    output logic                           busy,
    output logic                           overrun,
    output logic                           abort
);

    localparam int BW = (DATA_WID > 1) ? $clog2(DATA_WID) : 1;
    localparam int CW = $clog2(MEMORY_WID + 1);
    localparam int FW = DATA_WID * MEMORY_WID;

    if (DATA_WID < 2 || MEMORY_WID < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("sipo_frame_ctrl: unsupported parameters");
    end

    typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT} state_t;

    state_t              state, state_nxt;
    logic [BW-1:0]       bit_cnt;
    logic [DATA_WID-1:0] shift_reg, shift_nxt;
    logic [FW-1:0]       cap_buf, cap_nxt;
    logic                beat, word_done, frame_done;
    logic                start_acc, timeout;

    assign beat       = (state == CAPTURE) && ser_valid;
    assign word_done  = beat && (bit_cnt == BW'(DATA_WID - 1));
    assign frame_done = word_done && (word_cnt == CW'(MEMORY_WID - 1));
    assign start_acc  = start && ((state == IDLE) ||
                                  ((state == PRESENT) && frame_ready));

    // Merge the incoming bit and word so the final word lands in frame_data directly
    always_comb begin
        shift_nxt          = shift_reg;
        shift_nxt[bit_cnt] = ser_bit;
        cap_nxt            = cap_buf;
        cap_nxt[int'(word_cnt)*DATA_WID +: DATA_WID] = shift_nxt;
    end

`ifdef SIPO_CTRL_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC);
    logic [GW-1:0] gap_cnt;

    assign timeout = (state == CAPTURE) && !ser_valid &&
                     (gap_cnt == GW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            abort   <= 1'b0;
        end else begin
            abort <= timeout;
            if (state != CAPTURE || ser_valid || timeout)
                gap_cnt <= '0;
            else
                gap_cnt <= gap_cnt + GW'(1);
        end
    end
`else
    assign timeout = 1'b0;
    assign abort   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: begin
                if (frame_done)   state_nxt = PRESENT;
                else if (timeout) state_nxt = IDLE;
            end
            PRESENT: if (frame_ready) state_nxt = start ? CAPTURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shift_reg  <= '0;
            cap_buf    <= '0;
            frame_data <= '0;
            overrun    <= 1'b0;
        end else if (start_acc) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
            overrun   <= 1'b0;
        end else if (beat) begin
            shift_reg <= shift_nxt;
            if (word_done) begin
                cap_buf  <= cap_nxt;
                bit_cnt  <= '0;
                word_cnt <= word_cnt + CW'(1);
                if (frame_done)
                    frame_data <= cap_nxt;
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end else if (state == PRESENT && ser_valid) begin
            overrun <= 1'b1;
        end
    end

    assign frame_valid = (state == PRESENT);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed-vector bench for sipo_frame_ctrl (8-bit words, 4-word frames).
// Define SIPO_CTRL_TIMEOUT_EN for both files to exercise the abort path.
module tb_sipo_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ser_valid;
    logic        ser_bit;
    logic        frame_valid;
    logic        frame_ready;
    logic [31:0] frame_data;
    logic [2:0]  word_cnt;
    logic        busy;
    logic        overrun;
    logic        abort;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] FRM_A = 32'hF00F3CA5;
    localparam logic [31:0] FRM_B = 32'hDEADBEEF;
    localparam logic [31:0] FRM_C = 32'h0BADF00D;

    sipo_frame_ctrl #(
        .DATA_WID   (8),
        .MEMORY_WID (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ser_valid  (ser_valid),
        .ser_bit    (ser_bit),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .overrun    (overrun),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input logic [31:0] frm, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ser_valid = 1'b1;
            ser_bit   = frm[i];
            tick();
        end
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
    endtask

    initial begin
        logic [31:0] frm;
        rst_n = 1'b0; start = 1'b0; ser_valid = 1'b0;
        ser_bit = 1'b0; frame_ready = 1'b0;
        repeat (3) tick();
        chk("rst_fv",   {31'd0, frame_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy},        32'd0);
        chk("rst_data", frame_data,           32'd0);
        chk("rst_wcnt", {29'd0, word_cnt},    32'd0);
        chk("rst_ovr",  {31'd0, overrun},     32'd0);
        chk("rst_abt",  {31'd0, abort},       32'd0);
        rst_n = 1'b1;
        tick();

        // basic contiguous frame with consumer always ready
        frame_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("bas_busy", {31'd0, busy}, 32'd1);
        beats(FRM_A, 0, 30);
        chk("bas_fv_early", {31'd0, frame_valid}, 32'd0);
        beats(FRM_A, 31, 31);
        chk("bas_fv",   {31'd0, frame_valid}, 32'd1);
        chk("bas_data", frame_data,           FRM_A);
        chk("bas_wcnt", {29'd0, word_cnt},    32'd4);
        tick();
        chk("bas_fv_1cyc", {31'd0, frame_valid}, 32'd0);
        chk("bas_idle",    {31'd0, busy},        32'd0);

        // asynchronous reset in the middle of a capture
        start = 1'b1; tick(); start = 1'b0;
        beats(FRM_B, 0, 9);
        chk("mid_wcnt_pre", {29'd0, word_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy},     32'd0);
        chk("mid_wcnt", {29'd0, word_cnt}, 32'd0);
        chk("mid_data", frame_data,        32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("mid_fv_after", {31'd0, frame_valid}, 32'd0);
        chk("mid_busy_after", {31'd0, busy},      32'd0);

        // backpressure, overrun, ignored start in PRESENT, back-to-back start
        frame_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        beats(FRM_B, 0, 31);
        chk("bp_fv",   {31'd0, frame_valid}, 32'd1);
        chk("bp_data", frame_data,           FRM_B);
        chk("bp_ovr0", {31'd0, overrun},     32'd0);
        for (int i = 0; i < 10; i++) begin
            ser_valid = (i < 5);
            ser_bit   = i[0];
            start     = (i == 7);
            tick();
        end
        ser_valid = 1'b0; start = 1'b0;
        chk("bp_fv_hold",   {31'd0, frame_valid}, 32'd1);
        chk("bp_data_hold", frame_data,           FRM_B);
        chk("bp_ovr",       {31'd0, overrun},     32'd1);
        chk("bp_wcnt",      {29'd0, word_cnt},    32'd4);
        frame_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_fv",   {31'd0, frame_valid}, 32'd0);
        chk("b2b_busy", {31'd0, busy},        32'd1);
        chk("b2b_ovr",  {31'd0, overrun},     32'd0);
        chk("b2b_wcnt", {29'd0, word_cnt},    32'd0);

        // gapped input, start ignored while capturing
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 8; b++) begin
                ser_valid = 1'b1;
                ser_bit   = FRM_A[w*8+b];
                tick();
                ser_valid = 1'b0;
                start     = (w == 2 && b == 3);
                if (!(w == 3 && b == 7)) tick();
                start     = 1'b0;
            end
            chk($sformatf("gap_wcnt%0d", w + 1), {29'd0, word_cnt},
                32'(w + 1));
        end
        chk("gap_fv",   {31'd0, frame_valid}, 32'd1);
        chk("gap_data", frame_data,           FRM_A);
        chk("gap_ovr",  {31'd0, overrun},     32'd0);
        tick();
        chk("gap_done", {31'd0, busy}, 32'd0);

        // 12 beats then 16 idle cycles
        start = 1'b1; tick(); start = 1'b0;
        beats(FRM_C, 0, 11);
        repeat (15) tick();
        chk("to_abt_early",  {31'd0, abort}, 32'd0);
        chk("to_busy_early", {31'd0, busy},  32'd1);
        tick();
`ifdef SIPO_CTRL_TIMEOUT_EN
        chk("to_abt",  {31'd0, abort}, 32'd1);
        chk("to_busy", {31'd0, busy},  32'd0);
        chk("to_data", frame_data,     FRM_A);
        tick();
        chk("to_abt_pulse", {31'd0, abort}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        beats(FRM_C, 0, 31);
`else
        chk("to_abt",  {31'd0, abort}, 32'd0);
        chk("to_busy", {31'd0, busy},  32'd1);
        chk("to_data", frame_data,     FRM_A);
        beats(FRM_C, 12, 31);
`endif
        frm = frame_data;
        chk("to_fv",   {31'd0, frame_valid}, 32'd1);
        chk("to_frm",  frm,                  FRM_C);
        tick();
        chk("to_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
